// File: rtl/stream_parity_checker_pkg.sv
// Shared definitions for the stream parity checker.
//   state_t   : frame FSM states (IDLE, ACCUM, REPORT)
//   MODE_EVEN / MODE_ODD : parity mode encodings
//   ERR_CNT_W : width of the optional failed-frame counter
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/stream_parity_checker_beat_check.sv
// Combinational per-beat parity check.
//   data     : beat data
//   par      : parity bit carried with the beat
//   mode     : 0 = even, 1 = odd parity
//   p        : XOR reduction of data
//   beat_bad : 1 when par does not match p ^ mode
module parity_beat_check #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  input  logic              mode,
  output logic              p,
  output logic              beat_bad
);

  always_comb begin
    p        = ^data;
    beat_bad = (par != (p ^ mode));
  end

endmodule

// File: rtl/stream_parity_checker.sv
// Stream parity checker: validates DATA_W-bit beats with per-beat parity,
// grouped into frames of FRAME_LEN beats, and issues one report per frame.
// Optional build macro: PAR_ERR_CNT_EN adds err_frames (saturating count of
// reports handed off with out_ok = 0).
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   odd_mode       : parity mode, latched on a frame's first accepted beat
//   in_valid/ready : beat handshake; in_data, in_par carry the beat
//   out_valid/ready: report handshake
//   out_ok         : no failing beat in the frame
//   out_bad        : number of failing beats in the frame
//   out_frame_par  : XOR of all frame data bits, inverted in odd mode
//   err_frames     : (PAR_ERR_CNT_EN only) failed-frame count
module stream_parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 4,
  localparam int unsigned CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ok,
  output logic [CW-1:0]     out_bad,
  output logic              out_frame_par
`ifdef PAR_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_frames
`endif
);

  state_t        r_state;
  logic          r_mode;
  logic          r_acc;
  logic [CW-1:0] r_bad;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic          r_out_ok;
  logic [CW-1:0] r_out_bad;
  logic          r_out_par;

  logic          w_mode;
  logic          w_p;
  logic          w_beat_bad;
  logic          w_accept;
  logic          w_first;
  logic          w_acc_nxt;
  logic [CW-1:0] w_bad_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_last;

  // The first beat of a frame is checked against the live odd_mode, since
  // that is the value being latched; later beats use the latched copy.
  always_comb begin
    w_first   = (r_state == IDLE);
    w_mode    = w_first ? odd_mode : r_mode;
    in_ready  = (r_state != REPORT);
    w_accept  = in_valid && in_ready;
    w_acc_nxt = (w_first ? 1'b0 : r_acc) ^ w_p;
    w_bad_nxt = (w_first ? '0 : r_bad) + CW'(w_beat_bad);
    w_cnt_nxt = (w_first ? '0 : r_cnt) + CW'(1);
    w_last    = (w_cnt_nxt == CW'(FRAME_LEN));
  end

  parity_beat_check #(
    .DATA_W(DATA_W)
  ) u_beat_check (
    .data     (in_data),
    .par      (in_par),
    .mode     (w_mode),
    .p        (w_p),
    .beat_bad (w_beat_bad)
  );

  // Report fields are registered from the next-state accumulators so that
  // out_valid and its payload appear together the cycle after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= MODE_EVEN;
      r_acc       <= 1'b0;
      r_bad       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_ok    <= 1'b0;
      r_out_bad   <= '0;
      r_out_par   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_bad <= w_bad_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_first) r_mode <= odd_mode;
            if (w_last) begin
              r_state     <= REPORT;
              r_out_valid <= 1'b1;
              r_out_par   <= w_acc_nxt ^ w_mode;
              r_out_bad   <= w_bad_nxt;
              r_out_ok    <= (w_bad_nxt == '0);
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid     = r_out_valid;
    out_ok        = r_out_ok;
    out_bad       = r_out_bad;
    out_frame_par = r_out_par;
  end

`ifdef PAR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_frames;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_frames <= '0;
    end else if (r_state == REPORT && out_ready && !r_out_ok &&
                 r_err_frames != '1) begin
      r_err_frames <= r_err_frames + ERR_CNT_W'(1);
    end
  end

  always_comb err_frames = r_err_frames;
`endif

endmodule
